// File: rtl/cpuy_fetch.sv
`default_nettype none
// ============================================================================
// Module   : cpuy_fetch
// Purpose  : Instruction fetch and sequencing unit for the cpuy core. Reads
//            opcode/operand bytes from program memory over a req/ack port,
//            issues each instruction to the decoder/execution unit, and
//            applies taken jumps reported by the decoder.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            halt                 - blocks the start of a new opcode fetch
//            mem_addr/mem_rd_req  - program memory read address / request
//            mem_rd_ack/_data     - read completion and data
//            opcode/operand       - current instruction bytes
//            opcode_valid         - instruction is being issued
//            exec_ready           - execution unit done with instruction
//            jump_operation/_cond - decoder jump indication
//            pc                   - address of next byte to fetch
// Revision : 1.0 - initial release
// ============================================================================
module cpuy_fetch #(
   parameter int                  PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                halt,
   output logic [PC_WIDTH-1:0] mem_addr,
   output logic                mem_rd_req,
   input  logic                mem_rd_ack,
   input  logic [7:0]          mem_rd_data,
   output logic [7:0]          opcode,
   output logic [7:0]          operand,
   output logic                opcode_valid,
   input  logic                exec_ready,
   input  logic                jump_operation,
   input  logic                jump_condition,
   output logic [PC_WIDTH-1:0] pc
);

   localparam logic [1:0] c_st_fetch_op  = 2'd0;
   localparam logic [1:0] c_st_fetch_arg = 2'd1;
   localparam logic [1:0] c_st_issue     = 2'd2;

   localparam logic [PC_WIDTH-1:0] c_pc_one = {{(PC_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]          r_state;
   logic [1:0]          w_state_next;
   logic [PC_WIDTH-1:0] r_pc;
   logic [7:0]          r_opcode;
   logic [7:0]          r_operand;
   // Set once an opcode request has been raised and not yet acknowledged;
   // from then on halt can no longer withdraw the request.
   logic                r_op_pending;
   logic                w_req_raw;
   logic                w_valid;
   logic                w_fire;
   logic [PC_WIDTH-1:0] w_jump_target;

   // Jump target is the operand byte, truncated or zero-extended to PC width.
   generate
      if (PC_WIDTH <= 8) begin : g_target_narrow
         assign w_jump_target = r_operand[PC_WIDTH-1:0];
      end else begin : g_target_wide
         assign w_jump_target = {{(PC_WIDTH-8){1'b0}}, r_operand};
      end
   endgenerate

   // Reset masks the request so an ack arriving in a reset cycle never fires.
   assign mem_rd_req   = w_req_raw & ~rst;
   assign w_fire       = mem_rd_req & mem_rd_ack;
   assign mem_addr     = r_pc;
   assign pc           = r_pc;
   assign opcode       = r_opcode;
   assign operand      = r_operand;
   assign opcode_valid = w_valid;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_st_fetch_op;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_fetch_op: begin
            if (w_fire) begin
               w_state_next = mem_rd_data[7] ? c_st_fetch_arg : c_st_issue;
            end
         end
         c_st_fetch_arg: begin
            if (w_fire) begin
               w_state_next = c_st_issue;
            end
         end
         c_st_issue: begin
            if (exec_ready) begin
               w_state_next = c_st_fetch_op;
            end
         end
         default: w_state_next = c_st_fetch_op;
      endcase
   end

   // Output decode
   always_comb begin
      w_req_raw = 1'b0;
      w_valid   = 1'b0;
      case (r_state)
         c_st_fetch_op:  w_req_raw = ~halt | r_op_pending;
         c_st_fetch_arg: w_req_raw = 1'b1;
         c_st_issue:     w_valid   = 1'b1;
         default: begin
            w_req_raw = 1'b0;
            w_valid   = 1'b0;
         end
      endcase
   end

   // Datapath: program counter and instruction bytes
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc         <= RESET_PC;
         r_opcode     <= 8'h00;
         r_operand    <= 8'h00;
         r_op_pending <= 1'b0;
      end else begin
         r_op_pending <= 1'b0;
         case (r_state)
            c_st_fetch_op: begin
               r_op_pending <= mem_rd_req & ~mem_rd_ack;
               if (w_fire) begin
                  r_opcode  <= mem_rd_data;
                  r_operand <= 8'h00;
                  r_pc      <= r_pc + c_pc_one;
               end
            end
            c_st_fetch_arg: begin
               if (w_fire) begin
                  r_operand <= mem_rd_data;
                  r_pc      <= r_pc + c_pc_one;
               end
            end
            c_st_issue: begin
               if (exec_ready && jump_operation && jump_condition) begin
                  r_pc <= w_jump_target;
               end
            end
            default: r_op_pending <= 1'b0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cpuy_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpuy_fetch
// Purpose  : Self-checking bench for cpuy_fetch. A program memory model with
//            programmable ack delay answers fetches; expected issues are
//            queued by the stimulus and compared by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpuy_fetch;

   logic       clk;
   logic       rst;
   logic       halt;
   logic [7:0] mem_addr;
   logic       mem_rd_req;
   logic       mem_rd_ack;
   logic [7:0] mem_rd_data;
   logic [7:0] opcode;
   logic [7:0] operand;
   logic       opcode_valid;
   logic       exec_ready;
   logic       jump_operation;
   logic       jump_condition;
   logic [7:0] pc;

   cpuy_fetch #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
      .clk            (clk),
      .rst            (rst),
      .halt           (halt),
      .mem_addr       (mem_addr),
      .mem_rd_req     (mem_rd_req),
      .mem_rd_ack     (mem_rd_ack),
      .mem_rd_data    (mem_rd_data),
      .opcode         (opcode),
      .operand        (operand),
      .opcode_valid   (opcode_valid),
      .exec_ready     (exec_ready),
      .jump_operation (jump_operation),
      .jump_condition (jump_condition),
      .pc             (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- program memory model ----------------
   logic [7:0] mem [256];
   int         ack_delay;
   int         wait_cnt;
   logic       spurious_ack;

   assign mem_rd_ack  = (mem_rd_req && (wait_cnt >= ack_delay)) || spurious_ack;
   assign mem_rd_data = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_rd_req && !mem_rd_ack) wait_cnt <= wait_cnt + 1;
      else                           wait_cnt <= 0;
   end

   int cyc;
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [7:0] op;
      logic [7:0] arg;
      logic [7:0] pc;
   } exp_t;

   exp_t sb[$];
   int   checks;
   int   errors;
   int   issues_seen;
   int   issue_cyc [8];
   logic prev_valid;

   initial begin
      checks      = 0;
      errors      = 0;
      issues_seen = 0;
      prev_valid  = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares the first cycle of every issue against the queue.
   always @(negedge clk) begin
      exp_t e;
      if (opcode_valid === 1'b1 && prev_valid !== 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue actual opcode=%0h required no issue", opcode);
         end else begin
            e = sb.pop_front();
            check("issue_opcode",  {24'h0, opcode},  {24'h0, e.op});
            check("issue_operand", {24'h0, operand}, {24'h0, e.arg});
            check("issue_pc",      {24'h0, pc},      {24'h0, e.pc});
         end
         if (issues_seen < 8) issue_cyc[issues_seen] = cyc;
         issues_seen++;
      end
      prev_valid = opcode_valid;
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_exp(input logic [7:0] op, input logic [7:0] arg, input logic [7:0] p);
      exp_t e;
      e.op  = op;
      e.arg = arg;
      e.pc  = p;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      halt           = 1'b0;
      spurious_ack   = 1'b0;
      exec_ready     = 1'b1;
      jump_operation = 1'b0;
      jump_condition = 1'b0;
      ack_delay      = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      sb.delete();
      issues_seen = 0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_issues(input int n, input int budget);
      int k;
      k = 0;
      while (issues_seen < n && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      checks++;
      if (issues_seen < n) begin
         errors++;
         $display("FAIL issue_timeout actual=%0d issues required=%0d", issues_seen, n);
      end
   endtask

   task automatic check_queue_empty(input string name);
      check(name, sb.size(), 0);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int c0;
      rst          = 1'b1;
      spurious_ack = 1'b0;
      ack_delay    = 0;
      wait_cnt     = 0;

      // T1: reset state, then three 1-byte instructions back to back
      do_reset();
      check("rst_pc",      {24'h0, pc},      32'h00);
      check("rst_opcode",  {24'h0, opcode},  32'h00);
      check("rst_operand", {24'h0, operand}, 32'h00);
      check("rst_valid",   {31'h0, opcode_valid}, 32'h0);
      check("rst_req",     {31'h0, mem_rd_req},   32'h0);
      mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
      push_exp(8'h01, 8'h00, 8'h01);
      push_exp(8'h02, 8'h00, 8'h02);
      push_exp(8'h03, 8'h00, 8'h03);
      c0  = cyc;
      rst = 1'b0;
      wait_issues(3, 40);
      halt = 1'b1;
      check("t1_first_latency", issue_cyc[0] - c0, 1);
      check("t1_interval_a", issue_cyc[1] - issue_cyc[0], 2);
      check("t1_interval_b", issue_cyc[2] - issue_cyc[1], 2);
      repeat (3) begin
         @(posedge clk); #1;
         check("t1_halt_req", {31'h0, mem_rd_req}, 32'h0);
         check("t1_halt_pc",  {24'h0, pc},         32'h03);
      end
      check_queue_empty("t1_queue");

      // T2: 2-byte jump, taken, with delayed acks
      do_reset();
      mem[0] = 8'h80; mem[1] = 8'h10;
      ack_delay = 2; jump_operation = 1'b1; jump_condition = 1'b1;
      push_exp(8'h80, 8'h10, 8'h02);
      rst = 1'b0;
      wait_issues(1, 40);
      check("t2_pc_taken",   {24'h0, pc},       32'h10);
      check("t2_addr_taken", {24'h0, mem_addr}, 32'h10);
      check("t2_req_next",   {31'h0, mem_rd_req}, 32'h1);
      halt = 1'b1;

      // T2b: same program, jump condition false
      do_reset();
      mem[0] = 8'h80; mem[1] = 8'h10;
      ack_delay = 2; jump_operation = 1'b1; jump_condition = 1'b0;
      push_exp(8'h80, 8'h10, 8'h02);
      rst = 1'b0;
      wait_issues(1, 40);
      check("t2b_pc_not_taken",   {24'h0, pc},       32'h02);
      check("t2b_addr_not_taken", {24'h0, mem_addr}, 32'h02);
      halt = 1'b1;
      check_queue_empty("t2_queue");

      // T3: jump to 0xFF, 2-byte opcode there wraps operand fetch to 0x00
      do_reset();
      mem[0] = 8'h81; mem[1] = 8'hFF; mem[8'hFF] = 8'h90;
      jump_operation = 1'b1; jump_condition = 1'b1;
      push_exp(8'h81, 8'hFF, 8'h02);
      push_exp(8'h90, 8'h81, 8'h01);
      rst = 1'b0;
      wait_issues(1, 40);
      check("t3_pc_ff", {24'h0, pc}, 32'hFF);
      jump_condition = 1'b0;
      wait_issues(2, 40);
      halt = 1'b1;
      check("t3_pc_wrap", {24'h0, pc}, 32'h01);
      check_queue_empty("t3_queue");

      // T4: exec_ready held low while issuing; jump pulse must be ignored
      do_reset();
      mem[0] = 8'h85; mem[1] = 8'h20;
      exec_ready = 1'b0; jump_condition = 1'b1;
      push_exp(8'h85, 8'h20, 8'h02);
      rst = 1'b0;
      wait_issues(1, 40);
      for (int i = 0; i < 5; i++) begin
         check("t4_valid_held",  {31'h0, opcode_valid}, 32'h1);
         check("t4_opcode_held", {24'h0, opcode},       32'h85);
         check("t4_req_low",     {31'h0, mem_rd_req},   32'h0);
         check("t4_pc_held",     {24'h0, pc},           32'h02);
         jump_operation = (i == 1 || i == 2);
         @(posedge clk); #1;
      end
      jump_operation = 1'b0;
      exec_ready     = 1'b1;
      halt           = 1'b1;
      @(posedge clk); #1;
      check("t4_valid_drop", {31'h0, opcode_valid}, 32'h0);
      check("t4_pc_after",   {24'h0, pc},           32'h02);
      check("t4_req_halted", {31'h0, mem_rd_req},   32'h0);

      // T5: halt raised while the opcode request waits for ack
      do_reset();
      mem[0] = 8'h07;
      ack_delay = 3;
      push_exp(8'h07, 8'h00, 8'h01);
      rst = 1'b0;
      @(posedge clk); #1;
      halt = 1'b1;
      check("t5_req_kept", {31'h0, mem_rd_req}, 32'h1);
      wait_issues(1, 40);
      repeat (3) begin
         check("t5_req_stopped", {31'h0, mem_rd_req}, 32'h0);
         check("t5_pc_frozen",   {24'h0, pc},         32'h01);
         @(posedge clk); #1;
      end
      check_queue_empty("t5_queue");

      // T6: reset during FETCH_ARG with an ack in the reset cycle,
      //     then spurious acks while idle
      do_reset();
      mem[0] = 8'h80; mem[1] = 8'h33;
      ack_delay = 2;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("t6_arg_req",    {31'h0, mem_rd_req}, 32'h1);
      check("t6_arg_pc",     {24'h0, pc},         32'h01);
      check("t6_arg_opcode", {24'h0, opcode},     32'h80);
      @(posedge clk); #1;
      rst          = 1'b1;
      spurious_ack = 1'b1;
      @(posedge clk); #1;
      check("t6_rst_req",     {31'h0, mem_rd_req},   32'h0);
      check("t6_rst_valid",   {31'h0, opcode_valid}, 32'h0);
      check("t6_rst_pc",      {24'h0, pc},           32'h00);
      check("t6_rst_opcode",  {24'h0, opcode},       32'h00);
      check("t6_rst_operand", {24'h0, operand},      32'h00);
      spurious_ack = 1'b0;
      halt         = 1'b1;
      rst          = 1'b0;
      @(posedge clk); #1;
      spurious_ack = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      spurious_ack = 1'b0;
      @(posedge clk); #1;
      check("t6_idle_pc",     {24'h0, pc},           32'h00);
      check("t6_idle_opcode", {24'h0, opcode},       32'h00);
      check("t6_idle_valid",  {31'h0, opcode_valid}, 32'h0);
      check("t6_idle_issues", issues_seen,           0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound in case the stimulus itself stalls.
   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0t required=<200000", $time);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
